// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU: FSM states, instruction field positions
// and the jump-condition helper.
package hack_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        READ   = 3'd2,
        EXEC   = 3'd3,
        WRITE  = 3'd4
    } state_t;

    localparam int IS_C    = 15;
    localparam int A_BIT   = 12;
    localparam int COMP_HI = 11;
    localparam int COMP_LO = 6;
    localparam int DEST_A  = 5;
    localparam int DEST_D  = 4;
    localparam int DEST_M  = 3;
    localparam int JUMP_HI = 2;
    localparam int JUMP_LO = 0;

    function automatic logic jump_taken(input logic [2:0] jmp, input logic ng, input logic zr);
        return (jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr);
    endfunction

endpackage

// File: rtl/hack_alu.sv
// Combinational Hack ALU: optional zero/negate on each operand, add or AND,
// optional output negate, plus zero and negative flags.
module hack_alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);

    logic [15:0] x_z_s;
    logic [15:0] x_n_s;
    logic [15:0] y_z_s;
    logic [15:0] y_n_s;
    logic [15:0] f_s;

    // Operand conditioning, function select and flags
    always_comb begin
        x_z_s = zx ? 16'h0000 : x;
        x_n_s = nx ? ~x_z_s : x_z_s;
        y_z_s = zy ? 16'h0000 : y;
        y_n_s = ny ? ~y_z_s : y_z_s;
        f_s   = f ? (x_n_s + y_n_s) : (x_n_s & y_n_s);
        out   = no ? ~f_s : f_s;
        zr    = (out == 16'h0000);
        ng    = out[15];
    end

endmodule

// File: rtl/hack_cpu.sv
// Multi-cycle Hack CPU core: fetches from a 1-cycle ROM, decodes Hack
// instructions and accesses data memory over a stallable req/ack handshake.
module hack_cpu
    import hack_pkg::*;
#(
    parameter int PC_W   = 15,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [PC_W-1:0]   rom_addr,
    input  logic [15:0]       rom_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [PC_W-1:0]   pc
);

    state_t              state_r;
    state_t              state_s;
    logic [15:0]         a_r;
    logic [15:0]         d_r;
    logic [15:0]         ir_r;
    logic [15:0]         m_r;
    logic [PC_W-1:0]     pc_r;
    logic [PC_W-1:0]     pc_next_r;
    logic                mem_req_r;
    logic                mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [15:0]         mem_wdata_r;

    logic                ack_s;
    logic [5:0]          comp_s;
    logic [15:0]         alu_y_s;
    logic [15:0]         alu_out_s;
    logic                alu_zr_s;
    logic                alu_ng_s;
    logic [PC_W-1:0]     pc_inc_s;
    logic [PC_W-1:0]     pc_upd_s;
    logic                ir_unused_s;

    assign ack_s       = mem_ack & mem_req_r;
    assign comp_s      = ir_r[COMP_HI:COMP_LO];
    assign alu_y_s     = ir_r[A_BIT] ? m_r : a_r;
    assign pc_inc_s    = pc_r + PC_W'(1);
    // a_r still holds the pre-instruction A here, so the jump target is the old A
    assign pc_upd_s    = jump_taken(ir_r[JUMP_HI:JUMP_LO], alu_ng_s, alu_zr_s) ?
                         a_r[PC_W-1:0] : pc_inc_s;
    assign ir_unused_s = ^ir_r[15:13];

    assign rom_addr  = pc_r;
    assign pc        = pc_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

    hack_alu u_alu (
        .x   (d_r),
        .y   (alu_y_s),
        .zx  (comp_s[5]),
        .nx  (comp_s[4]),
        .zy  (comp_s[3]),
        .ny  (comp_s[2]),
        .f   (comp_s[1]),
        .no  (comp_s[0]),
        .out (alu_out_s),
        .zr  (alu_zr_s),
        .ng  (alu_ng_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            FETCH:  state_s = DECODE;
            DECODE: begin
                if (!rom_data[IS_C]) begin
                    state_s = FETCH;
                end else if (rom_data[A_BIT]) begin
                    state_s = READ;
                end else begin
                    state_s = EXEC;
                end
            end
            READ:   state_s = ack_s ? EXEC : READ;
            EXEC:   state_s = ir_r[DEST_M] ? WRITE : FETCH;
            WRITE:  state_s = ack_s ? FETCH : WRITE;
            default: state_s = FETCH;
        endcase
    end

    // Architectural registers and registered memory-port outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r         <= 16'h0000;
            d_r         <= 16'h0000;
            ir_r        <= 16'h0000;
            m_r         <= 16'h0000;
            pc_r        <= '0;
            pc_next_r   <= '0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 16'h0000;
        end else begin
            case (state_r)
                DECODE: begin
                    ir_r <= rom_data;
                    if (!rom_data[IS_C]) begin
                        a_r  <= {1'b0, rom_data[14:0]};
                        pc_r <= pc_inc_s;
                    end else if (rom_data[A_BIT]) begin
                        mem_req_r  <= 1'b1;
                        mem_we_r   <= 1'b0;
                        mem_addr_r <= a_r[ADDR_W-1:0];
                    end else begin
                        mem_req_r <= 1'b0;
                    end
                end
                READ: begin
                    if (ack_s) begin
                        m_r       <= mem_rdata;
                        mem_req_r <= 1'b0;
                    end else begin
                        mem_req_r <= 1'b1;
                    end
                end
                EXEC: begin
                    if (ir_r[DEST_A]) begin
                        a_r <= alu_out_s;
                    end else begin
                        a_r <= a_r;
                    end
                    if (ir_r[DEST_D]) begin
                        d_r <= alu_out_s;
                    end else begin
                        d_r <= d_r;
                    end
                    if (ir_r[DEST_M]) begin
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= a_r[ADDR_W-1:0];
                        mem_wdata_r <= alu_out_s;
                        pc_next_r   <= pc_upd_s;
                    end else begin
                        pc_r <= pc_upd_s;
                    end
                end
                WRITE: begin
                    if (ack_s) begin
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        pc_r      <= pc_next_r;
                    end else begin
                        mem_req_r <= 1'b1;
                    end
                end
                default: begin
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hack_cpu.sv
// Self-checking bench for hack_cpu: ROM/RAM models with programmable wait
// states; memory transfers are checked against an expected-transfer queue.
module tb_hack_cpu;
    import hack_pkg::*;

    typedef struct packed {
        logic        we;
        logic [14:0] addr;
        logic [15:0] data;
    } xfer_t;

    logic        clk;
    logic        rst_n;
    logic [14:0] rom_addr;
    logic [15:0] rom_data;
    logic        mem_req;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [14:0] pc;

    logic [15:0] rom [0:32767];
    logic [15:0] ram [0:32767];
    int          wait_n;
    bit          withhold;
    int          cnt;
    xfer_t       obs_q [$];
    xfer_t       exp_q [$];
    int          n_vec;
    int          n_err;

    hack_cpu #(.PC_W(15), .ADDR_W(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .pc        (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM with one-cycle read latency
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Data memory responder: ack after wait_n stall cycles unless withheld
    always @(negedge clk) begin
        mem_ack   <= rst_n && mem_req && !withhold && (cnt == wait_n);
        mem_rdata <= ram[mem_addr];
    end

    // Record each completed transfer for the scoreboard
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 0;
        end else if (mem_req && mem_ack) begin
            cnt <= 0;
            obs_q.push_back({mem_we, mem_addr, (mem_we ? mem_wdata : mem_rdata)});
        end else if (mem_req) begin
            cnt <= cnt + 1;
        end else begin
            cnt <= 0;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 32768; i++) rom[i] = 16'hEA80;
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        withhold = 1'b0;
        cycles(2);
        obs_q.delete();
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        xfer_t o;
        xfer_t e;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL %s unexpected transfer: got %h expected none", tag, o);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL %s transfer: got %h expected %h", tag, o, e);
                end
            end
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s missing transfers: got %0d pending expected 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        bit seen;
        clear_rom();
        rom[0] = 16'h0005;
        apply_reset();
        n_vec++;
        if (pc !== 15'd0 || dut.a_r !== 16'd0 || dut.d_r !== 16'd0 || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got pc=%h a=%h d=%h req=%b expected 0 0 0 0", pc, dut.a_r, dut.d_r, mem_req);
        end
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycles(1);
            seen = seen | mem_req;
        end
        n_vec++;
        if (dut.a_r !== 16'd5 || pc !== 15'd1 || seen !== 1'b0) begin
            n_err++;
            $display("FAIL a_instr: got a=%h pc=%h req_seen=%b expected 0005 0001 0", dut.a_r, pc, seen);
        end
        drain("reset");
    endtask

    task automatic test_back_to_back();
        clear_rom();
        rom[0] = 16'h0007;
        rom[1] = 16'hEC10;
        rom[2] = 16'hE7D0;
        wait_n = 0;
        apply_reset();
        cycles(5);
        n_vec++;
        if (dut.d_r !== 16'd7 || pc !== 15'd2) begin
            n_err++;
            $display("FAIL d_eq_a: got d=%h pc=%h expected 0007 0002", dut.d_r, pc);
        end
        cycles(3);
        n_vec++;
        if (dut.d_r !== 16'd8 || pc !== 15'd3) begin
            n_err++;
            $display("FAIL d_inc: got d=%h pc=%h expected 0008 0003", dut.d_r, pc);
        end
        drain("b2b");
    endtask

    task automatic test_write_stall();
        int k;
        clear_rom();
        rom[0] = 16'h0008;
        rom[1] = 16'hEC10;
        rom[2] = 16'h0064;
        rom[3] = 16'hE308;
        wait_n = 3;
        apply_reset();
        exp_q.push_back({1'b1, 15'd100, 16'd8});
        cycles(7);
        k = 0;
        while (mem_req !== 1'b1 && k < 20) begin
            cycles(1);
            k++;
        end
        n_vec++;
        if (k != 3) begin
            n_err++;
            $display("FAIL write_req_latency: got %0d cycles expected 3", k);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'd100 ||
                mem_wdata !== 16'd8 || pc !== 15'd3) begin
                n_err++;
                $display("FAIL write_hold[%0d]: got req=%b we=%b addr=%0d wdata=%0d pc=%0d expected 1 1 100 8 3",
                         i, mem_req, mem_we, mem_addr, mem_wdata, pc);
            end
            cycles(1);
        end
        n_vec++;
        if (pc !== 15'd4 || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL write_done: got pc=%0d req=%b expected 4 0", pc, mem_req);
        end
        drain("write_stall");
    endtask

    task automatic test_read_modify_write();
        clear_rom();
        rom[0] = 16'h0064;
        rom[1] = 16'hFDE8;
        ram[100] = 16'd41;
        wait_n = 1;
        apply_reset();
        exp_q.push_back({1'b0, 15'd100, 16'd41});
        exp_q.push_back({1'b1, 15'd100, 16'd42});
        cycles(4);
        n_vec++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 15'd100) begin
            n_err++;
            $display("FAIL read_req: got req=%b we=%b addr=%0d expected 1 0 100", mem_req, mem_we, mem_addr);
        end
        cycles(5);
        n_vec++;
        if (dut.a_r !== 16'd42 || pc !== 15'd2 || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL am_inc: got a=%0d pc=%0d req=%b expected 42 2 0", dut.a_r, pc, mem_req);
        end
        drain("rmw");
    endtask

    task automatic test_jumps();
        logic [15:0] d_ins [3];
        logic [15:0] j_ins [3];
        logic [14:0] exp_pc [3];
        d_ins[0] = 16'hEE90; j_ins[0] = 16'hE304; exp_pc[0] = 15'd20;
        d_ins[1] = 16'hEE90; j_ins[1] = 16'hE301; exp_pc[1] = 15'd3;
        d_ins[2] = 16'hEA90; j_ins[2] = 16'hE302; exp_pc[2] = 15'd20;
        wait_n = 0;
        for (int t = 0; t < 3; t++) begin
            clear_rom();
            rom[0] = d_ins[t];
            rom[1] = 16'h0014;
            rom[2] = j_ins[t];
            apply_reset();
            cycles(8);
            n_vec++;
            if (pc !== exp_pc[t]) begin
                n_err++;
                $display("FAIL jump[%0d]: got pc=%0d expected %0d", t, pc, exp_pc[t]);
            end
            drain("jump");
        end
    endtask

    task automatic test_pc_wrap();
        clear_rom();
        rom[0] = 16'h7FFF;
        rom[1] = 16'hEA87;
        rom[32767] = 16'h0003;
        wait_n = 0;
        apply_reset();
        cycles(5);
        n_vec++;
        if (pc !== 15'h7FFF) begin
            n_err++;
            $display("FAIL jmp_top: got pc=%h expected 7fff", pc);
        end
        cycles(2);
        n_vec++;
        if (pc !== 15'h0000 || dut.a_r !== 16'd3) begin
            n_err++;
            $display("FAIL pc_wrap: got pc=%h a=%h expected 0000 0003", pc, dut.a_r);
        end
        drain("wrap");
    endtask

    task automatic test_reset_mid_write();
        clear_rom();
        rom[0] = 16'h0064;
        rom[1] = 16'hE308;
        wait_n = 0;
        apply_reset();
        withhold = 1'b1;
        cycles(5);
        n_vec++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'd100) begin
            n_err++;
            $display("FAIL pending_write: got req=%b we=%b addr=%0d expected 1 1 100", mem_req, mem_we, mem_addr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (mem_req !== 1'b0 || pc !== 15'd0) begin
            n_err++;
            $display("FAIL async_abort: got req=%b pc=%0d expected 0 0", mem_req, pc);
        end
        cycles(2);
        withhold = 1'b0;
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (dut.state_r !== FETCH || mem_req !== 1'b0 || pc !== 15'd0) begin
            n_err++;
            $display("FAIL post_abort: got state=%0d req=%b pc=%0d expected 0 0 0", dut.state_r, mem_req, pc);
        end
        drain("abort");
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        wait_n   = 0;
        withhold = 1'b0;
        for (int i = 0; i < 32768; i++) ram[i] = 16'h0000;
        test_reset();
        test_back_to_back();
        test_write_stall();
        test_read_modify_write();
        test_jumps();
        test_pc_wrap();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
